// File: rtl/shared_pkg.sv
// Shared definitions for the APB4 register slave: FSM state encoding,
// default bus widths and the wait-state counter width.
package shared_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int WAIT_CTR_WIDTH     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb4_reg_slave_if.sv
// APB4 bus bundle between a requester (master) and the register slave.
interface apb4_reg_slave_if
    import shared_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [2:0]              PPROT;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PPROT, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PPROT, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state down-counter: loadable, decrements toward zero and saturates there.
module apb_wait_ctr
    import shared_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [WAIT_CTR_WIDTH-1:0] load_val,
    input  logic                      dec,
    output logic [WAIT_CTR_WIDTH-1:0] count,
    output logic                      zero
);

    logic [WAIT_CTR_WIDTH-1:0] count_r;

    // Count register: load has priority over decrement, never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WAIT_CTR_WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {WAIT_CTR_WIDTH{1'b0}})) begin
            count_r <= count_r - {{(WAIT_CTR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {WAIT_CTR_WIDTH{1'b0}});

endmodule

// File: rtl/apb4_reg_slave.sv
// APB4 completer exposing NUM_REGS registers with byte strobes, optional
// wait states, read-only hardware-sourced registers and secure-only access.
// All bus responses are registered; the transfer that reaches RESP is decoded
// on the clock edge that enters RESP.
module apb4_reg_slave
    import shared_pkg::*;
#(
    parameter int                ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}},
    parameter int                SECURE_ONLY = 0
)(
    input  logic                           PCLK,
    input  logic                           PRESETn,
    apb4_reg_slave_if.slave                apb,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(BYTES);
    // Only the byte-offset bits and the 8-bit word index matter to decode.
    localparam int CAP_W   = IDX_LSB + 8;
    localparam logic [CAP_W-1:0] ALIGN_MASK = CAP_W'(BYTES - 1);
    localparam logic [WAIT_CTR_WIDTH-1:0] WAIT_LOAD = WAIT_CTR_WIDTH'(WAIT_CYCLES);

    // Merge new data into old data on the byte lanes selected by strb.
    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [BYTES-1:0]      strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < BYTES; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    apb_state_t state_r;
    apb_state_t state_nxt;

    logic [CAP_W-1:0]      addr_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [BYTES-1:0]      strb_r;
    logic                  prot1_r;

    logic [CAP_W-1:0]      cur_addr_s;
    logic                  cur_write_s;
    logic [DATA_WIDTH-1:0] cur_wdata_s;
    logic [BYTES-1:0]      cur_strb_s;
    logic                  cur_prot1_s;
    logic [7:0]            cur_idx_s;
    logic                  cur_ro_s;
    logic [DATA_WIDTH-1:0] cur_rdata_s;
    logic [NUM_REGS-1:0]   idx_sel_s;
    logic [NUM_REGS-1:0]   wr_en_s;
    logic                  err_s;
    logic                  resp_go_s;
    logic                  setup_s;

    logic                      ctr_load_s;
    logic                      ctr_dec_s;
    logic [WAIT_CTR_WIDTH-1:0] ctr_count_s;
    logic                      ctr_zero_s;

    logic [DATA_WIDTH-1:0] prdata_r;
    logic                  pready_r;
    logic                  pslverr_r;
    logic [NUM_REGS-1:0]   wr_pulse_r;

    logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

    assign setup_s = apb.PSEL && !apb.PENABLE;

    apb_wait_ctr u_wait_ctr (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (ctr_load_s),
        .load_val (WAIT_LOAD),
        .dec      (ctr_dec_s),
        .count    (ctr_count_s),
        .zero     (ctr_zero_s)
    );

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and wait-counter control. RESP is entered on the edge where
    // the counter would reach zero, so PREADY rises WAIT_CYCLES+1 after setup.
    always_comb begin
        state_nxt  = state_r;
        ctr_load_s = 1'b0;
        ctr_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    ctr_load_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                ctr_dec_s = !ctr_zero_s;
                if (!(apb.PSEL && apb.PENABLE)) begin
                    state_nxt = IDLE;
                end else if (ctr_zero_s || (ctr_count_s == 4'd1)) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the transfer fields during the setup cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_r  <= {CAP_W{1'b0}};
            write_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
            strb_r  <= {BYTES{1'b0}};
            prot1_r <= 1'b0;
        end else if ((state_r == IDLE) && setup_s) begin
            addr_r  <= apb.PADDR[CAP_W-1:0];
            write_r <= apb.PWRITE;
            wdata_r <= apb.PWDATA;
            strb_r  <= apb.PSTRB;
            prot1_r <= apb.PPROT[1];
        end
    end

    // Transfer in decode: live bus while still in IDLE (zero-wait case goes
    // straight to RESP from setup), otherwise the captured copy.
    always_comb begin
        if (state_r == IDLE) begin
            cur_addr_s  = apb.PADDR[CAP_W-1:0];
            cur_write_s = apb.PWRITE;
            cur_wdata_s = apb.PWDATA;
            cur_strb_s  = apb.PSTRB;
            cur_prot1_s = apb.PPROT[1];
        end else begin
            cur_addr_s  = addr_r;
            cur_write_s = write_r;
            cur_wdata_s = wdata_r;
            cur_strb_s  = strb_r;
            cur_prot1_s = prot1_r;
        end
    end

    // Address decode, read mux and error detection for the current transfer.
    always_comb begin
        cur_idx_s   = cur_addr_s[CAP_W-1:IDX_LSB];
        cur_ro_s    = 1'b0;
        cur_rdata_s = {DATA_WIDTH{1'b0}};
        idx_sel_s   = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            idx_sel_s[i] = (cur_idx_s == 8'(i));
            cur_ro_s     = cur_ro_s | (idx_sel_s[i] & RO_MASK[i]);
            cur_rdata_s  = cur_rdata_s | ({DATA_WIDTH{idx_sel_s[i]}} & reg_view[i]);
        end
        err_s = ({1'b0, cur_idx_s} >= 9'(NUM_REGS))
              || ((cur_addr_s & ALIGN_MASK) != {CAP_W{1'b0}})
              || ((SECURE_ONLY != 0) && cur_prot1_s)
              || (cur_write_s && cur_ro_s);
        resp_go_s = (state_nxt == RESP);
        wr_en_s   = {NUM_REGS{resp_go_s && !err_s && cur_write_s}} & idx_sel_s;
    end

    // Registered completer response and per-register write strobes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prdata_r   <= {DATA_WIDTH{1'b0}};
            pready_r   <= 1'b0;
            pslverr_r  <= 1'b0;
            wr_pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            pready_r   <= resp_go_s;
            pslverr_r  <= resp_go_s && err_s;
            prdata_r   <= (resp_go_s && !err_s && !cur_write_s) ? cur_rdata_s
                                                                : {DATA_WIDTH{1'b0}};
            wr_pulse_r <= wr_en_s;
        end
    end

    assign apb.PRDATA  = prdata_r;
    assign apb.PREADY  = pready_r;
    assign apb.PSLVERR = pslverr_r;
    assign wr_pulse    = wr_pulse_r;

    // Register storage. Read-only indices never see a write enable, so their
    // flops stay at reset value and the visible contents come from hw_in.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] q_r;

        // Byte-lane write of one register.
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                q_r <= {DATA_WIDTH{1'b0}};
            end else if (wr_en_s[g] && !RO_MASK[g]) begin
                q_r <= strb_merge(q_r, cur_wdata_s, cur_strb_s);
            end
        end

        assign reg_view[g] = RO_MASK[g] ? hw_in[g*DATA_WIDTH +: DATA_WIDTH] : q_r;
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = reg_view[g];
    end

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Directed bench for apb4_reg_slave: two instances (0 and 3 wait states),
// both with register 7 read-only and secure-only access enabled.
module tb_apb4_reg_slave;

    localparam int DW = 32;
    localparam int NR = 8;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    logic [NR*DW-1:0] hw_in;
    logic [NR*DW-1:0] reg_a;
    logic [NR*DW-1:0] reg_b;
    logic [NR-1:0]    pulse_a;
    logic [NR-1:0]    pulse_b;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    always #5 PCLK = ~PCLK;

    apb4_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus_a ();
    apb4_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus_b ();

    apb4_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(0),
                     .RO_MASK(8'h80), .SECURE_ONLY(1)) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus_a.slave),
        .hw_in(hw_in), .reg_out(reg_a), .wr_pulse(pulse_a));

    apb4_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(3),
                     .RO_MASK(8'h80), .SECURE_ONLY(1)) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus_b.slave),
        .hw_in(hw_in), .reg_out(reg_b), .wr_pulse(pulse_b));

    typedef struct {
        int          d;          // 0 = zero-wait instance, 1 = three-wait instance
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_pulse;
        int          chk_idx;    // register to inspect afterwards, -1 for none
        logic [31:0] chk_val;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_bus(input int d, input logic sel, input logic en, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot);
        if (d == 0) begin
            bus_a.PSEL = sel; bus_a.PENABLE = en; bus_a.PWRITE = wr; bus_a.PADDR = addr;
            bus_a.PWDATA = wdata; bus_a.PSTRB = strb; bus_a.PPROT = prot;
        end else begin
            bus_b.PSEL = sel; bus_b.PENABLE = en; bus_b.PWRITE = wr; bus_b.PADDR = addr;
            bus_b.PWDATA = wdata; bus_b.PSTRB = strb; bus_b.PPROT = prot;
        end
    endtask

    task automatic sample(input int d, output logic rdy, output logic err,
                          output logic [31:0] rd, output logic [7:0] pls);
        if (d == 0) begin
            rdy = bus_a.PREADY; err = bus_a.PSLVERR; rd = bus_a.PRDATA; pls = pulse_a;
        end else begin
            rdy = bus_b.PREADY; err = bus_b.PSLVERR; rd = bus_b.PRDATA; pls = pulse_b;
        end
    endtask

    function automatic logic [31:0] reg_slice(input int d, input int idx);
        return (d == 0) ? reg_a[idx*32 +: 32] : reg_b[idx*32 +: 32];
    endfunction

    // One complete APB transfer; latency counts cycles from setup to PREADY.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, output int lat, output logic err,
                            output logic [31:0] rd, output logic [7:0] pls);
        logic rdy;
        logic done;
        set_bus(d, 1'b1, 1'b0, wr, addr, wdata, strb, prot);
        @(posedge PCLK); #1;
        set_bus(d, 1'b1, 1'b1, wr, addr, wdata, strb, prot);
        lat = 1; done = 1'b0; err = 1'b0; rd = 32'd0; pls = 8'd0;
        while (!done && lat <= 20) begin
            @(negedge PCLK);
            sample(d, rdy, err, rd, pls);
            if (rdy) begin
                done = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                lat++;
            end
        end
        check("ready_seen", 32'(done), 32'd1);
        @(posedge PCLK); #1;
        set_bus(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic        err;
        logic        rdy;
        logic [31:0] rd;
        logic [7:0]  pls;
        apb_xfer(v.d, v.wr, v.addr, v.wdata, v.strb, v.prot, lat, err, rd, pls);
        check({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check({v.name, ".pslverr"}, 32'(err), 32'(v.exp_err));
        check({v.name, ".prdata"}, rd, v.exp_rdata);
        check({v.name, ".wr_pulse"}, 32'(pls), 32'(v.exp_pulse));
        // Cycle after RESP: strobe and response are gone.
        @(negedge PCLK);
        sample(v.d, rdy, err, rd, pls);
        check({v.name, ".pready_after"}, 32'(rdy), 32'd0);
        check({v.name, ".pulse_after"}, 32'(pls), 32'd0);
        check({v.name, ".prdata_after"}, rd, 32'd0);
        if (v.chk_idx >= 0) begin
            check({v.name, ".reg"}, reg_slice(v.d, v.chk_idx), v.chk_val);
        end
    endtask

    // Every output of both instances at reset value; RO slice mirrors hw_in.
    task automatic check_reset_state(input string tag);
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        logic [7:0]  pls;
        for (int d = 0; d < 2; d++) begin
            sample(d, rdy, err, rd, pls);
            check($sformatf("%s.d%0d.pready", tag, d), 32'(rdy), 32'd0);
            check($sformatf("%s.d%0d.pslverr", tag, d), 32'(err), 32'd0);
            check($sformatf("%s.d%0d.prdata", tag, d), rd, 32'd0);
            check($sformatf("%s.d%0d.wr_pulse", tag, d), 32'(pls), 32'd0);
            for (int i = 0; i < NR; i++) begin
                check($sformatf("%s.d%0d.reg%0d", tag, d, i), reg_slice(d, i),
                      (i == 7) ? 32'hCAFE0007 : 32'd0);
            end
        end
    endtask

    // PSLVERR may only be high together with PREADY.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("pslverr_without_pready_a", 32'(bus_a.PSLVERR && !bus_a.PREADY), 32'd0);
            check("pslverr_without_pready_b", 32'(bus_b.PSLVERR && !bus_b.PREADY), 32'd0);
        end
    end

    function automatic vec_t mk(input int d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [2:0] prot, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic [7:0] exp_pulse,
                                input int chk_idx, input logic [31:0] chk_val,
                                input string name);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
        v.exp_lat = (d == 0) ? 1 : 4;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_pulse = exp_pulse;
        v.chk_idx = chk_idx; v.chk_val = chk_val; v.name = name;
        return v;
    endfunction

    vec_t vecs[17];
    vec_t post[3];

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_in[i*32 +: 32] = 32'h5A5A0000 + 32'(i);
        end
        hw_in[7*32 +: 32] = 32'hCAFE0007;
        set_bus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);

        //            d  wr    addr    wdata         strb  prot  err   rdata         pulse  idx  value
        vecs[0]  = mk(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 32'd0,        8'h02, 1, 32'hDEADBEEF, "a_wr_r1");
        vecs[1]  = mk(0, 1'b0, 32'h04, 32'd0,        4'h0, 3'd0, 1'b0, 32'hDEADBEEF, 8'h00, -1, 32'd0,       "a_rd_r1");
        vecs[2]  = mk(1, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 32'd0,        8'h02, 1, 32'hDEADBEEF, "b_wr_r1");
        vecs[3]  = mk(1, 1'b0, 32'h04, 32'd0,        4'h0, 3'd0, 1'b0, 32'hDEADBEEF, 8'h00, -1, 32'd0,       "b_rd_r1");
        vecs[4]  = mk(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'd0, 1'b0, 32'd0,        8'h04, 2, 32'h11223344, "a_wr_r2");
        vecs[5]  = mk(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 3'd0, 1'b0, 32'd0,        8'h04, 2, 32'h11BB33DD, "a_wr_r2_strb5");
        vecs[6]  = mk(0, 1'b0, 32'h08, 32'd0,        4'h0, 3'd0, 1'b0, 32'h11BB33DD, 8'h00, -1, 32'd0,       "a_rd_r2");
        vecs[7]  = mk(0, 1'b1, 32'h0C, 32'h12345678, 4'h0, 3'd0, 1'b0, 32'd0,        8'h08, 3, 32'd0,        "a_wr_r3_strb0");
        vecs[8]  = mk(0, 1'b0, 32'h20, 32'd0,        4'h0, 3'd0, 1'b1, 32'd0,        8'h00, -1, 32'd0,       "a_rd_range");
        vecs[9]  = mk(0, 1'b1, 32'h06, 32'h99999999, 4'hF, 3'd0, 1'b1, 32'd0,        8'h00, 1, 32'hDEADBEEF, "a_wr_unaligned");
        vecs[10] = mk(0, 1'b1, 32'h1C, 32'h77777777, 4'hF, 3'd0, 1'b1, 32'd0,        8'h00, 7, 32'hCAFE0007, "a_wr_ro");
        vecs[11] = mk(0, 1'b0, 32'h1C, 32'd0,        4'h0, 3'd0, 1'b0, 32'hCAFE0007, 8'h00, -1, 32'd0,       "a_rd_ro");
        vecs[12] = mk(0, 1'b1, 32'h10, 32'h44444444, 4'hF, 3'd2, 1'b1, 32'd0,        8'h00, 4, 32'd0,        "a_wr_nonsecure");
        vecs[13] = mk(0, 1'b0, 32'h04, 32'd0,        4'h0, 3'd2, 1'b1, 32'd0,        8'h00, -1, 32'd0,       "a_rd_nonsecure");
        vecs[14] = mk(1, 1'b0, 32'h20, 32'd0,        4'h0, 3'd0, 1'b1, 32'd0,        8'h00, -1, 32'd0,       "b_rd_range");
        vecs[15] = mk(1, 1'b1, 32'h1C, 32'h77777777, 4'hF, 3'd0, 1'b1, 32'd0,        8'h00, 7, 32'hCAFE0007, "b_wr_ro");
        vecs[16] = mk(1, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 3'd0, 1'b0, 32'd0,        8'h04, 2, 32'h00BB00DD, "b_wr_r2_strb5");

        post[0]  = mk(1, 1'b0, 32'h04, 32'd0,        4'h0, 3'd0, 1'b0, 32'd0,        8'h00, -1, 32'd0,       "post_b_rd_r1");
        post[1]  = mk(1, 1'b1, 32'h18, 32'h55AA55AA, 4'hF, 3'd0, 1'b0, 32'd0,        8'h40, 6, 32'h55AA55AA, "post_b_wr_r6");
        post[2]  = mk(0, 1'b0, 32'h04, 32'd0,        4'h0, 3'd0, 1'b0, 32'd0,        8'h00, -1, 32'd0,       "post_a_rd_r1");

        // Reset state.
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_state("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Table: transfers issue back-to-back per instance (setup right after RESP).
        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i]);
        end

        // Abort: drop PSEL during the wait states of a write on the 3-wait instance.
        begin
            logic        rdy;
            logic        err;
            logic [31:0] rd;
            logic [7:0]  pls;
            set_bus(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 3'd0);
            @(posedge PCLK); #1;
            set_bus(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 3'd0);
            @(posedge PCLK); #1;
            set_bus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
            for (int c = 0; c < 8; c++) begin
                @(negedge PCLK);
                sample(1, rdy, err, rd, pls);
                check($sformatf("abort.pready.c%0d", c), 32'(rdy), 32'd0);
                check($sformatf("abort.pulse.c%0d", c), 32'(pls), 32'd0);
            end
            check("abort.reg4", reg_slice(1, 4), 32'd0);
        end

        // Reset in the middle of a waited write: transfer discarded, all cleared.
        @(posedge PCLK); #1;
        set_bus(1, 1'b1, 1'b0, 1'b1, 32'h14, 32'h13579BDF, 4'hF, 3'd0);
        @(posedge PCLK); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h13579BDF, 4'hF, 3'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        check_reset_state("midreset");
        set_bus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (6) @(posedge PCLK);
        #1;
        check("postreset.reg5", reg_slice(1, 5), 32'd0);
        check("postreset.reg1_a", reg_slice(0, 1), 32'd0);

        for (int i = 0; i < 3; i++) begin
            run_vec(post[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
